hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard controller for the 5-stage core (F/D/E/M/W). Generates stall, flush and
//  forwarding selects for the datapath driven by the conditional-logic unit; sequences
//  load-use stalls, taken-branch squash, PC-write drain and variable-latency memory waits.
//  Keeps saturating stall/flush performance counters.
// PARAMETERS
//  REG_BITS    4      register-address width
//  PC_REG      15     register index never forwarded (reads return PC+8)
//  MEM_TIMEOUT 255    MEM_WAIT cycles before mem_timeout is raised (8-bit counter)
//  CNT_W       16     performance-counter width
// PORTS
//  clk          in   1         rising-edge clock
//  reset        in   1         synchronous, active-high
//  ra1_d/ra2_d  in   REG_BITS  source regs of instr in D
//  ra1_e/ra2_e  in   REG_BITS  source regs of instr in E
//  wa_e/wa_m/wa_w in REG_BITS  dest regs in E/M/W
//  reg_write_m/_w in 1         qualified reg_write in M/W
//  mem_to_reg_e in   1         instr in E is a load
//  pc_src_d/_e/_m in 1         instr in D/E/M writes PC (_e, _m already cond-qualified)
//  branch_taken_e in 1         qualified branch in E
//  mem_req_m    in   1         M stage issues a data-memory access
//  mem_ready_m  in   1         data memory completes access this cycle
//  stall_f/stall_d/stall_e/stall_m out 1  hold stage register
//  flush_d/flush_e/flush_w out 1  load bubble into stage register
//  fwd_a_e/fwd_b_e out 2       00 regfile, 01 result_w, 10 alu_result_m
//  mem_timeout  out  1         sticky, cleared only by reset
//  stall_cnt/flush_cnt out CNT_W  saturating event counters
// BEHAVIOUR
//  One clock; reset synchronous active-high. FSM states: RUN, MEM_WAIT. Outputs are
//  combinational from state+inputs; state, wait counter, sticky flag, counters registered.
//  Reset (while reset=1 and the cycle after): state=RUN, wait_cnt=0, mem_timeout=0,
//  counters=0; while reset=1 outputs forced: stalls=0, flush_d=flush_e=flush_w=1, fwd=00.
//  Forwarding (all states): fwd_a_e=10 if reg_write_m & wa_m==ra1_e & ra1_e!=PC_REG;
//   else 01 if reg_write_w & wa_w==ra1_e & ra1_e!=PC_REG; else 00. M wins over W.
//   fwd_b_e same on ra2_e.
//  RUN, evaluated in priority order:
//   1 mem_req_m & !mem_ready_m: stall_f/d/e/m=1, flush_w=1; next=MEM_WAIT; wait_cnt=1.
//   2 branch_taken_e: flush_d=flush_e=1; load-use and drain suppressed.
//   3 load-use (mem_to_reg_e & (wa_e==ra1_d | wa_e==ra2_d)): stall_f=stall_d=1, flush_e=1.
//   4 drain (pc_src_d|pc_src_e|pc_src_m): stall_f=1, flush_d=1.
//   3 and 4 both active: union of both signal sets.
//  MEM_WAIT: stall_f/d/e/m=1, flush_w=1; branch/load-use/drain ignored (pipe frozen).
//   mem_ready_m=1 -> outputs as RUN this cycle minus rule 1, next=RUN, wait_cnt=0.
//   else wait_cnt+=1, saturating at 255; wait_cnt==MEM_TIMEOUT sets mem_timeout;
//   FSM keeps waiting.
//  mem_req_m & mem_ready_m same cycle in RUN: no stall, zero-cycle access.
//  Counters: stall_cnt +1 per cycle with stall_f=1; flush_cnt +1 per cycle with
//   flush_d|flush_e. Both saturate at all-ones; neither counts while reset=1.
//  Reset mid-MEM_WAIT: next cycle RUN, wait_cnt=0, mem_timeout cleared.
// TESTING
//  T1 load-use: mem_to_reg_e=1, wa_e=3, ra2_d=3 -> stall_f=stall_d=flush_e=1 for one
//     cycle, stall_cnt=1.
//  T2 forwarding: reg_write_m=1, wa_m=5; reg_write_w=1, wa_w=5; ra1_e=5 -> fwd_a_e=10;
//     wa_m=PC_REG=ra1_e=15 -> fwd_a_e=00.
//  T3 branch beats load-use: branch_taken_e=1 plus T1 hazard -> flush_d=flush_e=1,
//     stall_f=0.
//  T4 mem wait: mem_req_m=1, mem_ready_m low 4 cycles -> stall_f..m=1, flush_w=1 for
//     4 cycles; ready on cycle 5 -> RUN, stall_cnt=4.
//  T5 timeout: MEM_TIMEOUT=3, ready never -> mem_timeout=1 on 3rd wait cycle and stays;
//     reset -> 0.
//  T6 drain + reset: pc_src_e=1 -> stall_f=flush_d=1; reset mid-MEM_WAIT -> RUN,
//     counters 0, flushes=1 during reset.

Source files
------------

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: stalls, flushes, forwarding, memory-wait sequencing
//
// Generates per-stage stall/flush controls and E-stage operand forwarding selects for a
// five-stage F/D/E/M/W core. Two states: RUN (normal hazard resolution) and MEM_WAIT
// (pipe frozen behind an outstanding data-memory access).
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   ra1_d, ra2_d                    source registers of the instruction in D
//   ra1_e, ra2_e                    source registers of the instruction in E
//   wa_e, wa_m, wa_w                destination registers in E / M / W
//   reg_write_m, reg_write_w        qualified register-write enables in M / W
//   mem_to_reg_e                    instruction in E is a load
//   pc_src_d, pc_src_e, pc_src_m    instruction in D / E / M writes the PC
//   branch_taken_e                  qualified taken branch in E
//   mem_req_m, mem_ready_m          data-memory request / completion in M
//   stall_f, stall_d, stall_e, stall_m   hold the stage register
//   flush_d, flush_e, flush_w       load a bubble into the stage register
//   fwd_a_e, fwd_b_e                00 regfile, 01 result_w, 10 alu_result_m
//   mem_timeout                     sticky memory-wait timeout flag
//   stall_cnt, flush_cnt            saturating performance counters

module hazard_ctrl #(
    parameter int REG_BITS    = 4,
    parameter int PC_REG      = 15,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [REG_BITS-1:0] ra1_d,
    input  logic [REG_BITS-1:0] ra2_d,
    input  logic [REG_BITS-1:0] ra1_e,
    input  logic [REG_BITS-1:0] ra2_e,
    input  logic [REG_BITS-1:0] wa_e,
    input  logic [REG_BITS-1:0] wa_m,
    input  logic [REG_BITS-1:0] wa_w,
    input  logic                reg_write_m,
    input  logic                reg_write_w,
    input  logic                mem_to_reg_e,
    input  logic                pc_src_d,
    input  logic                pc_src_e,
    input  logic                pc_src_m,
    input  logic                branch_taken_e,
    input  logic                mem_req_m,
    input  logic                mem_ready_m,
    output logic                stall_f,
    output logic                stall_d,
    output logic                stall_e,
    output logic                stall_m,
    output logic                flush_d,
    output logic                flush_e,
    output logic                flush_w,
    output logic [1:0]          fwd_a_e,
    output logic [1:0]          fwd_b_e,
    output logic                mem_timeout,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    flush_cnt
);

    localparam logic [REG_BITS-1:0] PC_IDX      = REG_BITS'(PC_REG);
    localparam logic [7:0]          TIMEOUT_VAL = 8'(MEM_TIMEOUT);
    localparam logic [1:0]          FWD_RF      = 2'b00;
    localparam logic [1:0]          FWD_W       = 2'b01;
    localparam logic [1:0]          FWD_M       = 2'b10;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_next;
    logic       timeout_q;
    logic       hold;
    logic       load_use;
    logic       drain;

    assign load_use = mem_to_reg_e & ((wa_e == ra1_d) | (wa_e == ra2_d));
    assign drain    = pc_src_d | pc_src_e | pc_src_m;

    // Forwarding is independent of the FSM: M (younger result) wins over W, and the
    // PC register is never forwarded because its reads are synthesized as PC+8.
    always_comb begin
        fwd_a_e = FWD_RF;
        fwd_b_e = FWD_RF;
        if (!reset) begin
            if (reg_write_m && wa_m == ra1_e && ra1_e != PC_IDX) begin
                fwd_a_e = FWD_M;
            end else if (reg_write_w && wa_w == ra1_e && ra1_e != PC_IDX) begin
                fwd_a_e = FWD_W;
            end
            if (reg_write_m && wa_m == ra2_e && ra2_e != PC_IDX) begin
                fwd_b_e = FWD_M;
            end else if (reg_write_w && wa_w == ra2_e && ra2_e != PC_IDX) begin
                fwd_b_e = FWD_W;
            end
        end
    end

    // Next-state and stall/flush decode.
    always_comb begin
        stall_f       = 1'b0;
        stall_d       = 1'b0;
        stall_e       = 1'b0;
        stall_m       = 1'b0;
        flush_d       = 1'b0;
        flush_e       = 1'b0;
        flush_w       = 1'b0;
        state_next    = state;
        wait_cnt_next = wait_cnt;
        hold          = 1'b0;

        // In RUN a new un-ready access freezes the pipe; in MEM_WAIT the pipe stays
        // frozen until the memory reports ready, whatever mem_req_m does meanwhile.
        case (state)
            RUN:      hold = mem_req_m & ~mem_ready_m;
            MEM_WAIT: hold = ~mem_ready_m;
            default:  hold = 1'b0;
        endcase

        if (hold) begin
            stall_f       = 1'b1;
            stall_d       = 1'b1;
            stall_e       = 1'b1;
            stall_m       = 1'b1;
            flush_w       = 1'b1;
            state_next    = MEM_WAIT;
            wait_cnt_next = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
        end else begin
            state_next    = RUN;
            wait_cnt_next = 8'd0;
            // A taken branch squashes D and E, so any load-use or drain hazard carried
            // by those instructions disappears with them.
            if (branch_taken_e) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else begin
                if (load_use) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end
                if (drain) begin
                    stall_f = 1'b1;
                    flush_d = 1'b1;
                end
            end
        end

        if (reset) begin
            stall_f       = 1'b0;
            stall_d       = 1'b0;
            stall_e       = 1'b0;
            stall_m       = 1'b0;
            flush_d       = 1'b1;
            flush_e       = 1'b1;
            flush_w       = 1'b1;
            state_next    = RUN;
            wait_cnt_next = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // The flag latches at the edge where the wait count reaches the limit and then
    // holds until reset, so software can see that a wait ever ran too long.
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_q <= 1'b0;
        end else if (hold && wait_cnt_next == TIMEOUT_VAL) begin
            timeout_q <= 1'b1;
        end
    end

    assign mem_timeout = timeout_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_f && stall_cnt != {CNT_W{1'b1}}) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if ((flush_d || flush_e) && flush_cnt != {CNT_W{1'b1}}) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed and randomized bench for hazard_ctrl against a behavioural model

module tb_hazard_ctrl;

    localparam int REG_BITS    = 4;
    localparam int PC_REG      = 15;
    localparam int MEM_TIMEOUT = 3;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic                clk = 1'b0;
    logic                reset;
    logic [REG_BITS-1:0] ra1_d, ra2_d, ra1_e, ra2_e, wa_e, wa_m, wa_w;
    logic                reg_write_m, reg_write_w, mem_to_reg_e;
    logic                pc_src_d, pc_src_e, pc_src_m, branch_taken_e;
    logic                mem_req_m, mem_ready_m;
    logic                stall_f, stall_d, stall_e, stall_m;
    logic                flush_d, flush_e, flush_w;
    logic [1:0]          fwd_a_e, fwd_b_e;
    logic                mem_timeout;
    logic [CNT_W-1:0]    stall_cnt, flush_cnt;

    hazard_ctrl #(
        .REG_BITS(REG_BITS), .PC_REG(PC_REG), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .ra1_d(ra1_d), .ra2_d(ra2_d), .ra1_e(ra1_e), .ra2_e(ra2_e),
        .wa_e(wa_e), .wa_m(wa_m), .wa_w(wa_w),
        .reg_write_m(reg_write_m), .reg_write_w(reg_write_w), .mem_to_reg_e(mem_to_reg_e),
        .pc_src_d(pc_src_d), .pc_src_e(pc_src_e), .pc_src_m(pc_src_m),
        .branch_taken_e(branch_taken_e), .mem_req_m(mem_req_m), .mem_ready_m(mem_ready_m),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Reference model: "waiting" means an access is outstanding, wait_len is the number
    // of consecutive frozen cycles so far (saturating at 255).
    bit model_valid = 0;
    bit m_waiting, m_timeout, m_frozen;
    int m_wait_len, m_stalls, m_flushes;
    bit e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw;
    int e_fa, e_fb;

    function automatic int fwd_ref(input logic [REG_BITS-1:0] ra);
        if (reg_write_m && wa_m == ra && ra != PC_REG) return 2;
        if (reg_write_w && wa_w == ra && ra != PC_REG) return 1;
        return 0;
    endfunction

    task automatic model_eval();
        bit lu;
        {e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw} = '0;
        e_fa = fwd_ref(ra1_e);
        e_fb = fwd_ref(ra2_e);
        m_frozen = 0;
        if (reset) begin
            e_fd = 1; e_fe = 1; e_fw = 1; e_fa = 0; e_fb = 0;
        end else begin
            m_frozen = m_waiting ? !mem_ready_m : (mem_req_m && !mem_ready_m);
            lu = mem_to_reg_e && (wa_e == ra1_d || wa_e == ra2_d);
            if (m_frozen) begin
                e_sf = 1; e_sd = 1; e_se = 1; e_sm = 1; e_fw = 1;
            end else if (branch_taken_e) begin
                e_fd = 1; e_fe = 1;
            end else begin
                if (lu) begin e_sf = 1; e_sd = 1; e_fe = 1; end
                if (pc_src_d || pc_src_e || pc_src_m) begin e_sf = 1; e_fd = 1; end
            end
        end
    endtask

    task automatic model_step();
        if (reset) begin
            m_waiting = 0; m_wait_len = 0; m_timeout = 0; m_stalls = 0; m_flushes = 0;
            model_valid = 1;
        end else begin
            if (e_sf && m_stalls < CNT_MAX) m_stalls++;
            if ((e_fd || e_fe) && m_flushes < CNT_MAX) m_flushes++;
            if (m_frozen) begin
                m_waiting = 1;
                if (m_wait_len < 255) m_wait_len++;
                if (m_wait_len == MEM_TIMEOUT) m_timeout = 1;
            end else begin
                m_waiting = 0;
                m_wait_len = 0;
            end
        end
    endtask

    // One clock: compare everything at the falling edge, advance the model, then return
    // just after the next rising edge so the caller can change inputs.
    task automatic cycle();
        @(negedge clk);
        model_eval();
        chk("stall_f", stall_f, e_sf);
        chk("stall_d", stall_d, e_sd);
        chk("stall_e", stall_e, e_se);
        chk("stall_m", stall_m, e_sm);
        chk("flush_d", flush_d, e_fd);
        chk("flush_e", flush_e, e_fe);
        chk("flush_w", flush_w, e_fw);
        chk("fwd_a_e", fwd_a_e, e_fa);
        chk("fwd_b_e", fwd_b_e, e_fb);
        if (model_valid) begin
            chk("mem_timeout", mem_timeout, m_timeout);
            chk("stall_cnt", stall_cnt, m_stalls);
            chk("flush_cnt", flush_cnt, m_flushes);
        end
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        {ra1_d, ra2_d, ra1_e, ra2_e} = '0;
        wa_e = 4'd1; wa_m = 4'd2; wa_w = 4'd4;
        {reg_write_m, reg_write_w, mem_to_reg_e} = '0;
        {pc_src_d, pc_src_e, pc_src_m, branch_taken_e} = '0;
        mem_req_m = 0; mem_ready_m = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        cycle();
        reset = 0;
    endtask

    function automatic logic [REG_BITS-1:0] rreg();
        case ($urandom_range(0, 3))
            0:       return 4'd3;
            1:       return 4'd5;
            2:       return 4'd15;
            default: return 4'($urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        reset = 1;
        idle_inputs();
        cycle();
        cycle();
        reset = 0;
        cycle();

        // T1 load-use
        mem_to_reg_e = 1; wa_e = 4'd3; ra2_d = 4'd3; ra1_d = 4'd0;
        #1;
        chk("t1_stall_f", stall_f, 1);
        chk("t1_stall_d", stall_d, 1);
        chk("t1_flush_e", flush_e, 1);
        cycle();
        idle_inputs();
        chk("t1_stall_cnt", stall_cnt, 1);

        // T2 forwarding, M over W, PC never forwarded
        reg_write_m = 1; wa_m = 4'd5; reg_write_w = 1; wa_w = 4'd5; ra1_e = 4'd5; ra2_e = 4'd5;
        #1;
        chk("t2_fwd_m", fwd_a_e, 2'b10);
        cycle();
        wa_m = 4'd6;
        #1;
        chk("t2_fwd_w", fwd_b_e, 2'b01);
        cycle();
        wa_m = 4'd15; wa_w = 4'd15; ra1_e = 4'd15;
        #1;
        chk("t2_fwd_pc", fwd_a_e, 2'b00);
        cycle();
        idle_inputs();

        // T3 branch beats load-use
        branch_taken_e = 1; mem_to_reg_e = 1; wa_e = 4'd3; ra2_d = 4'd3;
        #1;
        chk("t3_flush_d", flush_d, 1);
        chk("t3_flush_e", flush_e, 1);
        chk("t3_stall_f", stall_f, 0);
        cycle();
        idle_inputs();

        // T4 memory wait of four cycles
        do_reset();
        mem_req_m = 1; mem_ready_m = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t4_stall_m", stall_m, 1);
            chk("t4_flush_w", flush_w, 1);
            cycle();
        end
        mem_ready_m = 1;
        #1;
        chk("t4_release", stall_f, 0);
        cycle();
        idle_inputs();
        chk("t4_stall_cnt", stall_cnt, 4);
        cycle();

        // T5 timeout at the third wait cycle, sticky until reset
        do_reset();
        mem_req_m = 1; mem_ready_m = 0;
        for (int i = 1; i <= 6; i++) begin
            cycle();
            chk("t5_timeout", mem_timeout, (i >= 3) ? 1 : 0);
        end
        mem_req_m = 0; mem_ready_m = 1;
        cycle();
        chk("t5_sticky", mem_timeout, 1);
        do_reset();
        chk("t5_cleared", mem_timeout, 0);

        // T6 drain, then reset in the middle of a memory wait
        idle_inputs();
        pc_src_e = 1;
        #1;
        chk("t6_drain_stall", stall_f, 1);
        chk("t6_drain_flush", flush_d, 1);
        cycle();
        idle_inputs();
        mem_req_m = 1;
        cycle();
        cycle();
        reset = 1;
        #1;
        chk("t6_rst_flush_w", flush_w, 1);
        chk("t6_rst_stall", stall_f, 0);
        cycle();
        reset = 0;
        mem_req_m = 0;
        #1;
        chk("t6_run", stall_f, 0);
        chk("t6_cnt", stall_cnt, 0);
        cycle();

        // Randomized traffic with biased register choices so matches are frequent
        for (int n = 0; n < 3000; n++) begin
            reset          = ($urandom_range(0, 99) < 2);
            ra1_d          = rreg(); ra2_d = rreg();
            ra1_e          = rreg(); ra2_e = rreg();
            wa_e           = rreg(); wa_m  = rreg(); wa_w = rreg();
            reg_write_m    = ($urandom_range(0, 1) == 1);
            reg_write_w    = ($urandom_range(0, 1) == 1);
            mem_to_reg_e   = ($urandom_range(0, 2) == 0);
            pc_src_d       = ($urandom_range(0, 9) == 0);
            pc_src_e       = ($urandom_range(0, 9) == 0);
            pc_src_m       = ($urandom_range(0, 9) == 0);
            branch_taken_e = ($urandom_range(0, 6) == 0);
            mem_req_m      = ($urandom_range(0, 2) == 0);
            mem_ready_m    = ($urandom_range(0, 9) < 4);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
